// File: rtl/pipe_pkg.sv
// Shared types and constants for the fetch/decode front-end registers:
// FSM encoding, default halt encoding, stage register layouts, bubbles.
package pipe_pkg;

  // Front-end control state: normal running, draining after a halt, halted.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // Instruction encoding that starts the pipeline drain.
  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

  // Drain lasts three cycles (E, M, W); counter value of the last one.
  localparam logic [1:0] DRAIN_LAST = 2'd2;

  // F/D register layout.
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pcplus4;
  } fd_t;

  // D/E register layout.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       memto_reg;
    logic       mem_write;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] write_reg;
  } de_t;

  localparam int FD_W = $bits(fd_t);
  localparam int DE_W = $bits(de_t);

  // Bubble / cleared contents: no valid instruction, every control off.
  localparam logic [FD_W-1:0] FD_BUBBLE = {FD_W{1'b0}};
  localparam logic [DE_W-1:0] DE_BUBBLE = {DE_W{1'b0}};

  // Saturating 32-bit increment used by the performance counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) begin
      sat_inc32 = value;
    end else begin
      sat_inc32 = value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Width-parameterized pipeline register with load enable and synchronous
// clear. Priority: reset, then clear, then enable; otherwise hold.
module pipe_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] CLEAR_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Next contents: clear beats load, load beats hold.
  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = CLEAR_VAL;
    end else if (en) begin
      data_d = d;
    end else begin
      data_d = data_q;
    end
  end

  // Storage with synchronous active-high reset to all zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= {WIDTH{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_front_regs.sv
// Front-end pipeline registers: fetch PC, F/D and D/E stage registers,
// stall/flush performance counters and a halt-drain controller.
module pipe_front_regs
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Stall_F,
  input  logic        Stall_D,
  input  logic        Flush_D,
  input  logic        Flush_E,
  input  logic [31:0] PC_Next_F,
  input  logic [31:0] Instr_F,
  input  logic        RegWrite_D,
  input  logic        MemtoReg_D,
  input  logic        MemWrite_D,
  input  logic [4:0]  Rs_D,
  input  logic [4:0]  Rt_D,
  input  logic [4:0]  WriteReg_D,
  output logic [31:0] PC_F,
  output logic [31:0] Instr_D,
  output logic [31:0] PCPlus4_D,
  output logic        Valid_D,
  output logic        Valid_E,
  output logic        RegWrite_E,
  output logic        MemtoReg_E,
  output logic        MemWrite_E,
  output logic [4:0]  Rs_E,
  output logic [4:0]  Rt_E,
  output logic [4:0]  WriteReg_E,
  output logic [31:0] Stall_Cnt,
  output logic [31:0] Flush_Cnt,
  output logic        Done
);

  state_e      state_d, state_q;
  logic [1:0]  drain_cnt_d, drain_cnt_q;
  logic [31:0] pc_d, pc_q;
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] flush_cnt_d, flush_cnt_q;
  logic        done_d, done_q;

  logic        run_s;
  logic        halt_go_s;
  logic        fd_en_s, fd_clr_s;
  logic        de_clr_s;
  fd_t         fd_in_s, fd_q_s;
  de_t         de_in_s, de_q_s;

  assign run_s = (state_q == ST_RUN);

  // A halt in D starts draining only when it actually advances out of D.
  assign halt_go_s = fd_q_s.valid && (fd_q_s.instr == HALT_INSTR) &&
                     !Stall_D && !Flush_D;

  // Fetch PC: redirect (Flush_D) wins over a fetch stall; frozen once halting.
  always_comb begin
    pc_d = pc_q;
    if (!run_s) begin
      pc_d = pc_q;
    end else if (Flush_D || !Stall_F) begin
      pc_d = PC_Next_F;
    end else begin
      pc_d = pc_q;
    end
  end

  // F/D control: flush clears, stall holds, frozen outside RUN.
  assign fd_en_s  = run_s && !Stall_D;
  assign fd_clr_s = run_s && Flush_D;
  assign fd_in_s  = '{valid: 1'b1, instr: Instr_F, pcplus4: pc_q + 32'd4};

  // D/E control: loads every cycle, bubble on Flush_E or outside RUN.
  assign de_clr_s = Flush_E || !run_s;
  assign de_in_s  = '{valid:     fd_q_s.valid,
                      reg_write: RegWrite_D,
                      memto_reg: MemtoReg_D,
                      mem_write: MemWrite_D,
                      rs:        Rs_D,
                      rt:        Rt_D,
                      write_reg: WriteReg_D};

  // Performance counters: count only while running, saturate at all ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (run_s && Stall_D && !Flush_D) begin
      stall_cnt_d = sat_inc32(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (run_s && Flush_D) begin
      flush_cnt_d = sat_inc32(flush_cnt_q);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Halt FSM: RUN -> DRAIN on an advancing halt, three drain cycles, then HALTED.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_RUN: begin
        drain_cnt_d = 2'd0;
        if (halt_go_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d     = ST_HALTED;
          drain_cnt_d = 2'd0;
        end else begin
          state_d     = ST_DRAIN;
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end
      ST_HALTED: begin
        state_d     = ST_HALTED;
        drain_cnt_d = 2'd0;
      end
      default: begin
        state_d     = ST_RUN;
        drain_cnt_d = 2'd0;
      end
    endcase
    done_d = (state_d == ST_HALTED);
  end

  // Control and counter state with synchronous reset taking full priority.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= 2'd0;
      pc_q        <= RESET_PC;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      done_q      <= done_d;
    end
  end

  pipe_reg #(
    .WIDTH     (FD_W),
    .CLEAR_VAL (FD_BUBBLE)
  ) u_fd_reg (
    .clk (CLK),
    .rst (RESET),
    .en  (fd_en_s),
    .clr (fd_clr_s),
    .d   (fd_in_s),
    .q   (fd_q_s)
  );

  pipe_reg #(
    .WIDTH     (DE_W),
    .CLEAR_VAL (DE_BUBBLE)
  ) u_de_reg (
    .clk (CLK),
    .rst (RESET),
    .en  (1'b1),
    .clr (de_clr_s),
    .d   (de_in_s),
    .q   (de_q_s)
  );

  assign PC_F       = pc_q;
  assign Instr_D    = fd_q_s.instr;
  assign PCPlus4_D  = fd_q_s.pcplus4;
  assign Valid_D    = fd_q_s.valid;
  assign Valid_E    = de_q_s.valid;
  assign RegWrite_E = de_q_s.reg_write;
  assign MemtoReg_E = de_q_s.memto_reg;
  assign MemWrite_E = de_q_s.mem_write;
  assign Rs_E       = de_q_s.rs;
  assign Rt_E       = de_q_s.rt;
  assign WriteReg_E = de_q_s.write_reg;
  assign Stall_Cnt  = stall_cnt_q;
  assign Flush_Cnt  = flush_cnt_q;
  assign Done       = done_q;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Directed bench for pipe_front_regs: each cycle's stimulus pushes a
// hand-computed expected snapshot; a monitor pops and compares after the edge.
module tb_pipe_front_regs;

  logic        CLK, RESET;
  logic        Stall_F, Stall_D, Flush_D, Flush_E;
  logic [31:0] PC_Next_F, Instr_F;
  logic        RegWrite_D, MemtoReg_D, MemWrite_D;
  logic [4:0]  Rs_D, Rt_D, WriteReg_D;
  logic [31:0] PC_F, Instr_D, PCPlus4_D;
  logic        Valid_D, Valid_E;
  logic        RegWrite_E, MemtoReg_E, MemWrite_E;
  logic [4:0]  Rs_E, Rt_E, WriteReg_E;
  logic [31:0] Stall_Cnt, Flush_Cnt;
  logic        Done;

  pipe_front_regs #(.RESET_PC(32'h0000_0040)) dut (
    .CLK(CLK), .RESET(RESET), .Stall_F(Stall_F), .Stall_D(Stall_D),
    .Flush_D(Flush_D), .Flush_E(Flush_E), .PC_Next_F(PC_Next_F), .Instr_F(Instr_F),
    .RegWrite_D(RegWrite_D), .MemtoReg_D(MemtoReg_D), .MemWrite_D(MemWrite_D),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .WriteReg_D(WriteReg_D),
    .PC_F(PC_F), .Instr_D(Instr_D), .PCPlus4_D(PCPlus4_D),
    .Valid_D(Valid_D), .Valid_E(Valid_E),
    .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E), .MemWrite_E(MemWrite_E),
    .Rs_E(Rs_E), .Rt_E(Rt_E), .WriteReg_E(WriteReg_E),
    .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt), .Done(Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] pc, ins, p4;
    logic        vd, ve;
    logic [17:0] ctl;
    logic [31:0] sc, fc;
    logic        done;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  localparam logic [31:0] I1 = 32'h8C22_0000;
  localparam logic [31:0] I2 = 32'h0022_1820;
  localparam logic [31:0] I3 = 32'hAC43_0004;
  localparam logic [31:0] I4 = 32'h2042_0001;
  localparam logic [31:0] I5 = 32'h1000_0003;
  localparam logic [31:0] HLT = 32'hFFFF_FFFF;
  localparam logic [31:0] SAT = 32'hFFFF_FFFF;

  function automatic logic [17:0] mkctl(input logic rw, mr, mw,
                                        input logic [4:0] rs, rt, wr);
    mkctl = {rw, mr, mw, rs, rt, wr};
  endfunction

  logic [17:0] CA, CB, CC, CD, CE;
  logic [17:0] C0;

  task automatic chk(input string tag, input string f,
                     input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      $display("FAIL %s.%s: actual=%h required=%h", tag, f, act, req);
    end else begin
      n_pass++;
    end
  endtask

  task automatic push(input string tag, input logic [31:0] pc, ins, p4,
                      input logic vd, ve, input logic [17:0] ctl,
                      input logic [31:0] sc, fc, input logic done);
    exp_t e;
    e.tag = tag; e.pc = pc; e.ins = ins; e.p4 = p4; e.vd = vd; e.ve = ve;
    e.ctl = ctl; e.sc = sc; e.fc = fc; e.done = done;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of inputs at the falling edge; expectation pushed by caller.
  task automatic drive(input logic rst, sf, sd, fd, fe,
                       input logic [31:0] pcn, ins, input logic [17:0] ctl);
    @(negedge CLK);
    RESET = rst; Stall_F = sf; Stall_D = sd; Flush_D = fd; Flush_E = fe;
    PC_Next_F = pcn; Instr_F = ins;
    {RegWrite_D, MemtoReg_D, MemWrite_D, Rs_D, Rt_D, WriteReg_D} = ctl;
  endtask

  // Monitor: after each rising edge, compare outputs against the next expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.tag, "PC_F", PC_F, e.pc);
        chk(e.tag, "Instr_D", Instr_D, e.ins);
        chk(e.tag, "PCPlus4_D", PCPlus4_D, e.p4);
        chk(e.tag, "Valid_D", {31'd0, Valid_D}, {31'd0, e.vd});
        chk(e.tag, "Valid_E", {31'd0, Valid_E}, {31'd0, e.ve});
        chk(e.tag, "ctl_E", {14'd0, RegWrite_E, MemtoReg_E, MemWrite_E, Rs_E, Rt_E, WriteReg_E},
            {14'd0, e.ctl});
        chk(e.tag, "Stall_Cnt", Stall_Cnt, e.sc);
        chk(e.tag, "Flush_Cnt", Flush_Cnt, e.fc);
        chk(e.tag, "Done", {31'd0, Done}, {31'd0, e.done});
      end
    end
  end

  // Stimulus: directed cycles with hand-computed post-edge state.
  initial begin
    CA = mkctl(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
    CB = mkctl(1'b1, 1'b1, 1'b0, 5'd4, 5'd5, 5'd6);
    CC = mkctl(1'b0, 1'b0, 1'b1, 5'd7, 5'd8, 5'd9);
    CD = mkctl(1'b1, 1'b0, 1'b1, 5'd31, 5'd0, 5'd17);
    CE = mkctl(1'b0, 1'b1, 1'b0, 5'd10, 5'd20, 5'd30);
    C0 = 18'd0;
    RESET = 1'b1; Stall_F = 1'b0; Stall_D = 1'b0; Flush_D = 1'b0; Flush_E = 1'b0;
    PC_Next_F = 32'd0; Instr_F = 32'd0;
    {RegWrite_D, MemtoReg_D, MemWrite_D, Rs_D, Rt_D, WriteReg_D} = 18'd0;

    // reset state
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, C0);
    push("reset", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, C0, 32'd0, 32'd0, 1'b0);
    // first fetch into D
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44, I1, CA);
    push("load1", 32'h44, I1, 32'h44, 1'b1, 1'b0, CA, 32'd0, 32'd0, 1'b0);
    // load-use: stall F and D, bubble into E
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h48, I2, CB);
    push("loaduse", 32'h44, I1, 32'h44, 1'b1, 1'b0, C0, 32'd1, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h48, I2, CB);
    push("resume", 32'h48, I2, 32'h48, 1'b1, 1'b1, CB, 32'd1, 32'd0, 1'b0);
    // D stall only, PC still advances
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4C, I3, CC);
    push("stall_d", 32'h4C, I2, 32'h48, 1'b1, 1'b1, CC, 32'd2, 32'd0, 1'b0);
    // branch redirect overrides stalls
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, I3, CD);
    push("redirect", 32'h100, 32'h0, 32'h0, 1'b0, 1'b1, CD, 32'd2, 32'd1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104, I4, CE);
    push("after_redir", 32'h104, I4, 32'h104, 1'b1, 1'b0, CE, 32'd2, 32'd1, 1'b0);
    // flush D and E together
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, I5, CA);
    push("flush_de", 32'h200, 32'h0, 32'h0, 1'b0, 1'b0, C0, 32'd2, 32'd2, 1'b0);
    // halt reaches D, then is flushed: no drain
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h204, HLT, CA);
    push("halt_in_d", 32'h204, HLT, 32'h204, 1'b1, 1'b0, CA, 32'd2, 32'd2, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300, I1, CB);
    push("halt_flushed", 32'h300, 32'h0, 32'h0, 1'b0, 1'b1, CB, 32'd2, 32'd3, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h304, I1, CC);
    push("still_run", 32'h304, I1, 32'h304, 1'b1, 1'b0, CC, 32'd2, 32'd3, 1'b0);

    // saturation: preload stall counter, then three stall cycles
    @(negedge CLK);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    push("preload", 32'h304, I1, 32'h308, 1'b1, 1'b1, CC, 32'hFFFF_FFFE, 32'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h308, I2, CD);
      push("sat_stall", 32'h304, I1, 32'h308, 1'b1, 1'b1, CD, SAT, 32'd3, 1'b0);
    end

    // halt fetched, reaches D, drains for three cycles, then Done
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h400, HLT, CD);
    push("halt_fetch", 32'h400, HLT, 32'h308, 1'b1, 1'b1, CD, SAT, 32'd3, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h404, I2, CE);
    push("drain_enter", 32'h404, I2, 32'h404, 1'b1, 1'b1, CE, SAT, 32'd3, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h500, I3, CA);
    push("drain1", 32'h404, I2, 32'h404, 1'b1, 1'b0, C0, SAT, 32'd3, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h500, I3, CA);
    push("drain2", 32'h404, I2, 32'h404, 1'b1, 1'b0, C0, SAT, 32'd3, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h500, I3, CA);
    push("halted", 32'h404, I2, 32'h404, 1'b1, 1'b0, C0, SAT, 32'd3, 1'b1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h600, I4, CB);
      push("halted_hold", 32'h404, I2, 32'h404, 1'b1, 1'b0, C0, SAT, 32'd3, 1'b1);
    end

    // reset out of HALTED, with stall and flush asserted alongside
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h700, I5, CC);
    push("reset2", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, C0, 32'd0, 32'd0, 1'b0);
    // second halt; reset during its second drain cycle
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44, HLT, CB);
    push("halt2_in_d", 32'h44, HLT, 32'h44, 1'b1, 1'b0, CB, 32'd0, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h48, I1, CC);
    push("drain2_enter", 32'h48, I1, 32'h48, 1'b1, 1'b1, CC, 32'd0, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h99C, I4, CD);
    push("drain2_c1", 32'h48, I1, 32'h48, 1'b1, 1'b0, C0, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h99C, I4, CD);
    push("reset_mid", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, C0, 32'd0, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44, I2, CA);
    push("run_again1", 32'h44, I2, 32'h44, 1'b1, 1'b0, CA, 32'd0, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h48, I3, CB);
    push("run_again2", 32'h48, I3, 32'h48, 1'b1, 1'b1, CB, 32'd0, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4C, I4, CC);
    push("run_again3", 32'h4C, I4, 32'h4C, 1'b1, 1'b1, CC, 32'd0, 32'd0, 1'b0);

    repeat (2) @(negedge CLK);
    chk("end", "sb_left", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_front_regs.md
PIPE_FRONT_REGS -- requirements
Module: pipe_front_regs

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter HALT_INSTR, default 32'hFFFF_FFFF, meaning the instruction encoding that starts pipeline drain.
REQ-003 SHALL have ports, one per line:
- CLK  in  1  single clock, all state on rising edge
- RESET  in  1  synchronous, active-high
- Stall_F  in  1  hold PC
- Stall_D  in  1  hold F/D register
- Flush_D  in  1  clear F/D register (redirect taken)
- Flush_E  in  1  insert bubble into D/E register
- PC_Next_F  in  32  next PC, already muxed upstream
- Instr_F  in  32  fetched instruction
- RegWrite_D, MemtoReg_D, MemWrite_D  in  1 each  decode controls
- Rs_D, Rt_D, WriteReg_D  in  5 each  decode register fields
- PC_F  out  32  current fetch PC
- Instr_D, PCPlus4_D  out  32 each  F/D contents
- Valid_D, Valid_E  out  1 each  stage holds a real instruction
- RegWrite_E, MemtoReg_E, MemWrite_E  out  1 each  D/E controls
- Rs_E, Rt_E, WriteReg_E  out  5 each  D/E register fields
- Stall_Cnt, Flush_Cnt  out  32 each  performance counters
- Done  out  1  pipeline drained after halt

Function
REQ-004 PC_F SHALL load PC_Next_F each cycle unless Stall_F=1 and Flush_D=0; Flush_D overrides Stall_F so redirects are never lost.
REQ-005 F/D register SHALL load Instr_F, PC_F+4 (mod 2^32) and Valid_D=1 when Stall_D=0 and Flush_D=0.
REQ-006 F/D SHALL hold all contents when Stall_D=1 and Flush_D=0.
REQ-007 F/D SHALL clear Instr_D, PCPlus4_D and Valid_D to 0 when Flush_D=1, regardless of Stall_D.
REQ-008 D/E register SHALL load all decode controls/fields and Valid_E=Valid_D each cycle when Flush_E=0.
REQ-009 When Flush_E=1, D/E SHALL load zeros (bubble, Valid_E=0), regardless of other inputs.
REQ-010 Stall_Cnt SHALL increment by 1 on each cycle with Stall_D=1 and Flush_D=0 while in state RUN; it saturates at 32'hFFFF_FFFF.
REQ-011 Flush_Cnt SHALL increment by 1 on each cycle with Flush_D=1 while in RUN; it saturates at 32'hFFFF_FFFF.
REQ-012 FSM states SHALL be RUN, DRAIN and HALTED.
REQ-013 RUN->DRAIN SHALL occur when Valid_D=1, Instr_D==HALT_INSTR, Stall_D=0 and Flush_D=0.
REQ-014 In DRAIN, a 2-bit counter SHALL count 3 cycles (for E, M and W), then enter HALTED.
REQ-015 In DRAIN and HALTED, PC_F and F/D SHALL freeze, and D/E SHALL load bubbles.
REQ-016 HALTED SHALL be absorbing until RESET; Done=1 only in HALTED.
REQ-017 A flushed halt (Flush_D=1 in the cycle Instr_D==HALT_INSTR) SHALL NOT start DRAIN.

Reset
REQ-018 On RESET=1 at a rising edge, state SHALL be as follows: PC_F=RESET_PC; all F/D, D/E, counters, Valid_D, Valid_E and Done = 0; FSM=RUN.
REQ-019 RESET SHALL take priority over every stall, flush and FSM condition, including mid-DRAIN.

Structure
REQ-020 FSM state encoding, HALT_INSTR default and the bubble/zero control constant SHALL live in a shared package pipe_pkg.
REQ-021 One sub-module, pipe_reg (width-parameterized register with enable and synchronous clear), SHALL be instantiated for F/D and D/E.

Verification
REQ-022 Reset with RESET_PC=32'h0000_0040 -> PC_F=0x40, Valid_D=0, Stall_Cnt=0, Done=0 on first post-reset cycle.
REQ-023 Load-use case: Stall_F=Stall_D=Flush_E=1 for 1 cycle with Instr_D=0x8C220000 -> PC_F and Instr_D held, Valid_E=0 next cycle, Stall_Cnt=1.
REQ-024 Branch redirect: Flush_D=1, Stall_F=1, PC_Next_F=0x100 -> PC_F=0x100, Instr_D=0, Valid_D=0, Flush_Cnt=1.
REQ-025 Halt: Instr_F=0xFFFF_FFFF fetched -> DRAIN entered one cycle after it reaches D, Done=1 exactly 3 cycles later, PC_F frozen thereafter.
REQ-026 RESET asserted during the second DRAIN cycle -> FSM=RUN, Done=0, PC_F=RESET_PC next cycle.
REQ-027 Counter preloaded (forced) to 32'hFFFF_FFFE with 3 stall cycles -> Stall_Cnt ends at 32'hFFFF_FFFF.
